// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end and its consumers in ID.
package if_pkg;

    localparam logic [31:0] IF_RESET_PC = 32'h1c00_0000;

    // Word-sized read encoding on the inst_sram bus.
    localparam logic [1:0]  IF_SIZE_WORD = 2'b10;

    // Exception-bus bit that ID raises for an address-error-fetch.
    localparam int          EBUS_ADEF_BIT = 6;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } if_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit occupancy count and a synchronous flush.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // NOTE: storage is deliberately not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Multi-outstanding instruction fetch with a PC-tracking pending FIFO and an
// instruction queue in front of ID; redirects flush younger state and drop stale responses.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OS   = 4,
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        fetch_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_adef
);
    localparam int CW = $clog2(MAX_OS + 1);
    localparam int QW = $bits(if_entry_t);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic halted_q, halted_d;

    logic [31:0] pend_dout;
    logic [CW-1:0] pend_count;
    logic pend_full, pend_empty;

    logic [$clog2(DEPTH+1)-1:0] q_count;
    logic q_full, q_empty, q_push, q_pop, q_flush;
    logic [QW-1:0] q_din_bits, q_dout_bits;
    if_entry_t q_din, q_head;

    logic accept, resp_live, adef_fire;

    always_comb begin
        inst_sram_req = ~reset & ~redirect_valid & ~fetch_stall & ~halted_q
                      & (fetch_pc_q[1:0] == 2'b00)
                      & (inflight_q < CW'(MAX_OS))
                      & ~pend_full
                      & (32'(inflight_q) + 32'(q_count) < 32'(DEPTH));
        accept    = inst_sram_req & inst_sram_addr_ok;
        resp_live = inst_sram_data_ok & (discard_q == '0);
        adef_fire = (fetch_pc_q[1:0] != 2'b00) & ~halted_q & (inflight_q == '0)
                  & ~q_full & ~redirect_valid;

        q_push  = resp_live | adef_fire;
        q_pop   = out_valid & out_ready;
        q_flush = reset | redirect_valid;
        q_din   = adef_fire ? '{pc: fetch_pc_q, inst: 32'h0, adef: 1'b1}
                            : '{pc: pend_dout, inst: inst_sram_rdata, adef: 1'b0};
        q_din_bits = q_din;

        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        halted_d   = halted_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
            inflight_d = '0;
            // Every live request becomes a discard; a response this cycle retires one of them either way.
            discard_d  = discard_q + inflight_q - CW'(inst_sram_data_ok);
        end else begin
            if (accept)    fetch_pc_d = fetch_pc_q + 32'd4;
            if (adef_fire) halted_d   = 1'b1;
            inflight_d = inflight_q + CW'(accept) - CW'(resp_live);
            discard_d  = discard_q - CW'(inst_sram_data_ok & ~resp_live);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            halted_q   <= halted_d;
        end
    end

    sync_fifo #(.WIDTH(32), .DEPTH(MAX_OS)) u_pending (
        .clk   (clk),
        .flush (reset),
        .push  (accept),
        .din   (fetch_pc_q),
        .pop   (inst_sram_data_ok),
        .dout  (pend_dout),
        .count (pend_count),
        .full  (pend_full),
        .empty (pend_empty)
    );

    sync_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .flush (q_flush),
        .push  (q_push),
        .din   (q_din_bits),
        .pop   (q_pop),
        .dout  (q_dout_bits),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign q_head    = if_entry_t'(q_dout_bits);
    assign out_valid = ~q_empty;
    assign out_pc    = q_head.pc;
    assign out_inst  = q_head.inst;
    assign out_adef  = q_head.adef & out_valid;

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = IF_SIZE_WORD;
    assign inst_sram_addr  = fetch_pc_q;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

`ifndef SYNTHESIS
    a_data_ok_empty: assert property (@(posedge clk) disable iff (reset)
        !(inst_sram_data_ok && pend_empty));
    a_addr_ok_no_req: assert property (@(posedge clk) disable iff (reset)
        !(inst_sram_addr_ok && !inst_sram_req));
    a_queue_overflow: assert property (@(posedge clk) disable iff (reset)
        !(q_push && q_full && !q_pop && !redirect_valid));
    a_pending_tracks: assert property (@(posedge clk) disable iff (reset)
        (inflight_q + discard_q == pend_count));
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with an in-order SRAM bridge model and an ID-side pop log.
module tb_if_fetch_queue;
    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic [3:0]  inst_sram_wstrb;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic        fetch_stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready, out_adef;
    logic [31:0] out_pc, out_inst;

    int n_cmp = 0;
    int n_err = 0;

    if_fetch_queue dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .fetch_stall       (fetch_stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_inst          (out_inst),
        .out_adef          (out_adef)
    );

    always #5 clk = ~clk;

    // SRAM bridge model: accepts when enabled, answers in order one cycle later when enabled.
    logic        addr_en, data_en;
    logic [31:0] mem_salt;
    logic [63:0] bq[$];
    int          pend_cnt = 0;
    logic [31:0] pend_head = '0;
    logic        m_rst, m_take, m_acc;
    logic [31:0] m_addr;

    assign inst_sram_addr_ok = addr_en & inst_sram_req;
    assign inst_sram_data_ok = data_en & (pend_cnt != 0);
    assign inst_sram_rdata   = pend_head;

    always begin
        @(posedge clk);
        m_rst  = reset;
        m_take = inst_sram_data_ok;
        m_acc  = inst_sram_req & inst_sram_addr_ok;
        m_addr = inst_sram_addr;
        #1;
        if (m_rst) bq.delete();
        else begin
            if (m_take && bq.size() != 0) void'(bq.pop_front());
            if (m_acc) bq.push_back({mem_salt, m_addr});
        end
        pend_cnt  = bq.size();
        pend_head = (bq.size() != 0) ? (bq[0][31:0] ^ bq[0][63:32]) : 32'h0;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
        int          cyc;
    } pop_t;

    pop_t log_q[$];
    int   cyc = 0;
    pop_t pe;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && out_valid && out_ready) begin
            pe.pc   = out_pc;
            pe.inst = out_inst;
            pe.adef = out_adef;
            pe.cyc  = cyc;
            log_q.push_back(pe);
        end
    end

    function automatic pop_t log_at(input int i);
        pop_t e;
        e.pc   = 'x;
        e.inst = 'x;
        e.adef = 1'bx;
        e.cyc  = -1000;
        if (i < log_q.size()) e = log_q[i];
        return e;
    endfunction

    function automatic int count_below(input logic [31:0] lim);
        int n = 0;
        foreach (log_q[i]) if (log_q[i].pc < lim) n++;
        return n;
    endfunction

    task automatic set_idle();
        fetch_stall    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        addr_en        = 1'b0;
        data_en        = 1'b0;
        out_ready      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        log_q.delete();
    endtask

    task automatic test_reset();
        set_idle();
        mem_salt = 32'hffff_ffff;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (inst_sram_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", inst_sram_req); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_adef !== 1'b0) begin n_err++; $display("FAIL reset_out_adef: got %b want 0", out_adef); end
        reset = 1'b0;
        #1;
        n_cmp++; if (inst_sram_req !== 1'b1) begin n_err++; $display("FAIL post_reset_req: got %b want 1", inst_sram_req); end
        n_cmp++; if (inst_sram_addr !== RST_PC) begin n_err++; $display("FAIL post_reset_addr: got %h want %h", inst_sram_addr, RST_PC); end
        n_cmp++; if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== {1'b0, 2'b10, 4'h0, 32'h0}) begin
            n_err++; $display("FAIL tie_offs: got wr=%b size=%b wstrb=%h wdata=%h want 0/10/0/0",
                              inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
        end
    endtask

    task automatic test_streaming();
        int max_os = 0;
        pop_t e;
        do_reset();
        addr_en = 1'b1; data_en = 1'b1; out_ready = 1'b1;
        repeat (16) begin
            @(negedge clk);
            if (pend_cnt > max_os) max_os = pend_cnt;
        end
        n_cmp++; if (max_os > 4) begin n_err++; $display("FAIL stream_max_inflight: got %0d want <=4", max_os); end
        for (int i = 0; i < 8; i++) begin
            e = log_at(i);
            n_cmp++; if (e.pc !== RST_PC + 32'(4 * i) || e.inst !== ((RST_PC + 32'(4 * i)) ^ mem_salt) || e.adef !== 1'b0) begin
                n_err++; $display("FAIL stream_entry%0d: got pc=%h inst=%h adef=%b want pc=%h inst=%h adef=0",
                                  i, e.pc, e.inst, e.adef, RST_PC + 32'(4 * i), (RST_PC + 32'(4 * i)) ^ mem_salt);
            end
        end
        n_cmp++; if (log_at(7).cyc - log_at(0).cyc !== 7) begin
            n_err++; $display("FAIL stream_rate: got %0d cycles for 8 pops want 7", log_at(7).cyc - log_at(0).cyc);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        do_reset();
        addr_en = 1'b1; data_en = 1'b1;
        repeat (20) begin
            #1;
            if (inst_sram_req && inst_sram_addr_ok) acc++;
            @(negedge clk);
        end
        n_cmp++; if (acc !== 4) begin n_err++; $display("FAIL bp_accepts: got %0d want 4", acc); end
        n_cmp++; if (inst_sram_req !== 1'b0) begin n_err++; $display("FAIL bp_req_blocked: got %b want 0", inst_sram_req); end
        n_cmp++; if (out_valid !== 1'b1 || pend_cnt !== 0) begin
            n_err++; $display("FAIL bp_queue_full: got out_valid=%b pending=%0d want 1/0", out_valid, pend_cnt);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (inst_sram_req !== 1'b0) begin n_err++; $display("FAIL bp_req_before_pop: got %b want 0", inst_sram_req); end
        @(negedge clk);
        n_cmp++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RST_PC + 32'h10) begin
            n_err++; $display("FAIL bp_req_resume: got req=%b addr=%h want 1/%h", inst_sram_req, inst_sram_addr, RST_PC + 32'h10);
        end
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (log_at(i).pc !== RST_PC + 32'(4 * i)) begin
                n_err++; $display("FAIL bp_drain%0d: got pc=%h want %h", i, log_at(i).pc, RST_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        addr_en = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        addr_en = 1'b0;
        n_cmp++; if (pend_cnt !== 3) begin n_err++; $display("FAIL redir3_inflight: got %0d want 3", pend_cnt); end
        redirect_valid = 1'b1; redirect_pc = 32'h1c00_0100; addr_en = 1'b1;
        #1;
        n_cmp++; if (inst_sram_req !== 1'b0) begin n_err++; $display("FAIL redir3_req_in_R: got %b want 0", inst_sram_req); end
        @(negedge clk);
        redirect_valid = 1'b0; data_en = 1'b1;
        log_q.delete();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir3_flush: got %b want 0", out_valid); end
        repeat (12) @(negedge clk);
        n_cmp++; if (log_at(0).pc !== 32'h1c00_0100 || log_at(0).inst !== (32'h1c00_0100 ^ mem_salt)) begin
            n_err++; $display("FAIL redir3_first: got pc=%h inst=%h want %h/%h", log_at(0).pc, log_at(0).inst,
                              32'h1c00_0100, 32'h1c00_0100 ^ mem_salt);
        end
        n_cmp++; if (log_at(1).pc !== 32'h1c00_0104) begin n_err++; $display("FAIL redir3_second: got %h want 1c000104", log_at(1).pc); end
        n_cmp++; if (count_below(32'h1c00_0100) !== 0) begin
            n_err++; $display("FAIL redir3_stale: got %0d stale entries want 0", count_below(32'h1c00_0100));
        end
    endtask

    task automatic test_redirect_coincident();
        do_reset();
        addr_en = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h1c00_0200; data_en = 1'b1;
        #1;
        n_cmp++; if (inst_sram_data_ok !== 1'b1 || inst_sram_req !== 1'b0) begin
            n_err++; $display("FAIL coin_setup: got data_ok=%b req=%b want 1/0", inst_sram_data_ok, inst_sram_req);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        log_q.delete();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL coin_dropped: got out_valid=%b want 0", out_valid); end
        repeat (10) @(negedge clk);
        n_cmp++; if (log_at(0).pc !== 32'h1c00_0200) begin n_err++; $display("FAIL coin_first: got %h want 1c000200", log_at(0).pc); end
        n_cmp++; if (count_below(32'h1c00_0200) !== 0) begin
            n_err++; $display("FAIL coin_stale: got %0d stale entries want 0", count_below(32'h1c00_0200));
        end
    endtask

    task automatic test_adef();
        logic req_seen = 1'b0;
        do_reset();
        addr_en = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        addr_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h1c00_0102;
        @(negedge clk);
        redirect_valid = 1'b0; data_en = 1'b1; addr_en = 1'b1;
        log_q.delete();
        repeat (12) begin
            #1;
            req_seen = req_seen | inst_sram_req;
            @(negedge clk);
        end
        n_cmp++; if (req_seen !== 1'b0) begin n_err++; $display("FAIL adef_req_halted: got req=%b want 0", req_seen); end
        n_cmp++; if (log_q.size() !== 1) begin n_err++; $display("FAIL adef_count: got %0d entries want 1", log_q.size()); end
        n_cmp++; if (log_at(0).pc !== 32'h1c00_0102 || log_at(0).inst !== 32'h0 || log_at(0).adef !== 1'b1) begin
            n_err++; $display("FAIL adef_entry: got pc=%h inst=%h adef=%b want 1c000102/0/1",
                              log_at(0).pc, log_at(0).inst, log_at(0).adef);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h1c00_1000;
        @(negedge clk);
        redirect_valid = 1'b0;
        log_q.delete();
        #1;
        n_cmp++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_1000) begin
            n_err++; $display("FAIL adef_release: got req=%b addr=%h want 1/1c001000", inst_sram_req, inst_sram_addr);
        end
        repeat (6) @(negedge clk);
        n_cmp++; if (log_at(0).pc !== 32'h1c00_1000 || log_at(0).adef !== 1'b0) begin
            n_err++; $display("FAIL adef_after: got pc=%h adef=%b want 1c001000/0", log_at(0).pc, log_at(0).adef);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        addr_en = 1'b1; data_en = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_full_setup: got out_valid=%b want 1", out_valid); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_full_clear: got out_valid=%b want 0", out_valid); end
        reset = 1'b0;
        data_en = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (pend_cnt !== 4) begin n_err++; $display("FAIL rst_burst_setup: got %0d in flight want 4", pend_cnt); end
        reset = 1'b1; data_en = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_burst_valid: got %b want 0", out_valid); end
        mem_salt = 32'h1234_5678;
        reset = 1'b0; out_ready = 1'b1;
        log_q.delete();
        #1;
        n_cmp++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RST_PC) begin
            n_err++; $display("FAIL rst_burst_req: got req=%b addr=%h want 1/%h", inst_sram_req, inst_sram_addr, RST_PC);
        end
        repeat (8) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (log_at(i).pc !== RST_PC + 32'(4 * i) || log_at(i).inst !== ((RST_PC + 32'(4 * i)) ^ mem_salt)) begin
                n_err++; $display("FAIL rst_burst_resp%0d: got pc=%h inst=%h want %h/%h", i, log_at(i).pc, log_at(i).inst,
                                  RST_PC + 32'(4 * i), (RST_PC + 32'(4 * i)) ^ mem_salt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_adef();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
